// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: two pipeline lanes plus a 2-entry mul/div result FIFO.
// Optional macro WB_ARB_BYPASS_EN lets an md result go straight to a free port while the FIFO is empty.
module rf_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        l0_we,
  input  logic [4:0]  l0_addr,
  input  logic [31:0] l0_data,
  input  logic        l1_we,
  input  logic [4:0]  l1_addr,
  input  logic [31:0] l1_data,
  input  logic        md_valid,
  input  logic [4:0]  md_addr,
  input  logic [31:0] md_data,
  output logic        md_ready,
  output logic        wb_stall,
  output logic        rf_we0,
  output logic [4:0]  rf_waddr0,
  output logic [31:0] rf_wdata0,
  output logic        rf_we1,
  output logic [4:0]  rf_waddr1,
  output logic [31:0] rf_wdata1,
  output logic [1:0]  q_count
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  logic [1:0]  count_q, count_d;
  logic [2:0]  age_q, age_d;
  logic [4:0]  addr_q [2];
  logic [4:0]  addr_d [2];
  logic [31:0] data_q [2];
  logic [31:0] data_d [2];

  logic v0, v1, stall, l0_act, l1_act, free0, free1;
  logic sq0, sq1, c0, c1, dr0, dr1, hp, ep, collapse;
  logic md_acc, byp, byp_p, push, keep0, keep1;

  logic [1:0]  p_we;
  logic [4:0]  p_addr [2];
  logic [31:0] p_data [2];

  assign v0     = (count_q != 2'd0);
  assign v1     = (count_q == 2'd2);
  assign stall  = v0 && (age_q >= LIMIT);
  assign l0_act = l0_we && !stall;
  assign l1_act = l1_we && !stall;
  assign free0  = !l0_act;
  assign free1  = !l1_act;

  // A younger lane write to the same register makes a queued result obsolete.
  assign sq0 = v0 && ((l0_act && (l0_addr == addr_q[0])) || (l1_act && (l1_addr == addr_q[0])));
  assign sq1 = v1 && ((l0_act && (l0_addr == addr_q[1])) || (l1_act && (l1_addr == addr_q[1])));
  assign c0  = v0 && !sq0;
  assign c1  = v1 && !sq1;

  // In-order drain: entry 1 only writes if the head is gone or also writes this cycle.
  assign dr0 = c0 && (free0 || free1);
  assign hp  = !free0;
  assign dr1 = c0 ? (c1 && free0 && free1) : (c1 && (free0 || free1));
  assign ep  = c0 ? 1'b1 : !free0;
  assign collapse = dr0 && dr1 && (addr_q[0] == addr_q[1]);

  assign md_ready = (count_q < 2'd2);
  assign md_acc   = md_valid && md_ready && (md_addr != 5'd0) &&
                    !((l0_act && (l0_addr == md_addr)) || (l1_act && (l1_addr == md_addr)));

`ifdef WB_ARB_BYPASS_EN
  assign byp   = md_acc && !v0 && (free0 || free1);
  assign byp_p = !free0;
`else
  assign byp   = 1'b0;
  assign byp_p = 1'b0;
`endif

  assign push  = md_acc && !byp;
  assign keep0 = v0 && !sq0 && !dr0;
  assign keep1 = v1 && !sq1 && !dr1;

  always_comb begin
    p_we      = 2'b00;
    p_addr[0] = 5'd0;
    p_addr[1] = 5'd0;
    p_data[0] = 32'd0;
    p_data[1] = 32'd0;
    if (l0_act) begin
      p_we[0]   = (l0_addr != 5'd0);
      p_addr[0] = l0_addr;
      p_data[0] = l0_data;
    end
    if (l1_act) begin
      p_we[1]   = (l1_addr != 5'd0);
      p_addr[1] = l1_addr;
      p_data[1] = l1_data;
    end
    if (dr1) begin
      p_we[ep]   = 1'b1;
      p_addr[ep] = addr_q[1];
      p_data[ep] = data_q[1];
    end
    // Two queued writes to one register in a cycle: only the younger one lands.
    if (dr0 && !collapse) begin
      p_we[hp]   = 1'b1;
      p_addr[hp] = addr_q[0];
      p_data[hp] = data_q[0];
    end
    if (byp) begin
      p_we[byp_p]   = 1'b1;
      p_addr[byp_p] = md_addr;
      p_data[byp_p] = md_data;
    end
  end

  assign rf_we0    = resetn && p_we[0];
  assign rf_we1    = resetn && p_we[1];
  assign rf_waddr0 = rf_we0 ? p_addr[0] : 5'd0;
  assign rf_wdata0 = rf_we0 ? p_data[0] : 32'd0;
  assign rf_waddr1 = rf_we1 ? p_addr[1] : 5'd0;
  assign rf_wdata1 = rf_we1 ? p_data[1] : 32'd0;
  assign wb_stall  = stall;
  assign q_count   = count_q;

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    if (keep0) begin
      if (!keep1 && push) begin
        addr_d[1] = md_addr;
        data_d[1] = md_data;
      end
    end else if (keep1) begin
      addr_d[0] = addr_q[1];
      data_d[0] = data_q[1];
      if (push) begin
        addr_d[1] = md_addr;
        data_d[1] = md_data;
      end
    end else if (push) begin
      addr_d[0] = md_addr;
      data_d[0] = md_data;
    end
    count_d = 2'(keep0) + 2'(keep1) + 2'(push);
    if (keep0) age_d = (age_q == 3'd7) ? 3'd7 : age_q + 3'd1;
    else       age_d = 3'd0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q   <= 2'd0;
      age_q     <= 3'd0;
      addr_q[0] <= 5'd0;
      addr_q[1] <= 5'd0;
      data_q[0] <= 32'd0;
      data_q[1] <= 32'd0;
    end else begin
      count_q <= count_d;
      age_q   <= age_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule
